// File: rtl/puf_pkg.sv
// Shared types and elaboration helpers for the arbiter-PUF evaluation engine.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SETTLE,
        SAMPLE,
        RECOVER,
        DONE
    } state_t;

    function automatic bit params_ok(input int n_stages, input int n_eval,
                                     input int settle, input int recover);
        return (n_stages >= 1) && (n_eval >= 1) && ((n_eval % 2) == 1) &&
               (settle >= 3) && (recover >= 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/puf_delay_line.sv
// Challenge-controlled crossover race chain terminated by the arbiter flop.
module puf_delay_line #(
    parameter int N_STAGES = 64
) (
    input  logic                launch,
    input  logic [N_STAGES-1:0] chal,
    output logic                arb_raw
);

    (* dont_touch = "true", keep = "true" *) logic path0;
    (* dont_touch = "true", keep = "true" *) logic path1;
    (* dont_touch = "true", keep = "true" *) logic arb_q;

    // Each stage either passes both edges straight through or swaps them.
    for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
        (* dont_touch = "true", keep = "true" *) logic in0;
        (* dont_touch = "true", keep = "true" *) logic in1;
        (* dont_touch = "true", keep = "true" *) logic out0;
        (* dont_touch = "true", keep = "true" *) logic out1;
        if (i == 0) begin : g_head
            assign in0 = launch;
            assign in1 = launch;
        end else begin : g_link
            assign in0 = g_stage[i-1].out0;
            assign in1 = g_stage[i-1].out1;
        end
        assign out0 = chal[i] ? in1 : in0;
        assign out1 = chal[i] ? in0 : in1;
    end

    assign path0 = g_stage[N_STAGES-1].out0;
    assign path1 = g_stage[N_STAGES-1].out1;

    // Path 1 arriving clocks in path 0: a captured 1 means path 0 won the race.
    always_ff @(posedge path1 or negedge launch) begin
        if (!launch) arb_q <= 1'b0;
        else         arb_q <= path0;
    end

    assign arb_raw = arb_q;

endmodule

// File: rtl/arbiter_puf_engine.sv
// Arbiter-PUF engine: races each accepted challenge N_EVAL times and majority-votes the outcome.
module arbiter_puf_engine
    import puf_pkg::*;
#(
    parameter int  N_STAGES       = 64,
    parameter int  N_EVAL         = 7,
    parameter int  SETTLE_CYCLES  = 4,
    parameter int  RECOVER_CYCLES = 2,
    localparam int CONF_W         = $clog2(N_EVAL + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                chal_valid,
    output logic                chal_ready,
    input  logic [N_STAGES-1:0] chal,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp,
    output logic [CONF_W-1:0]   resp_conf,
    output logic                busy
);

    localparam int TMR_W = $clog2(max_int(SETTLE_CYCLES, RECOVER_CYCLES) + 1);
    localparam logic [CONF_W-1:0] N_EVAL_C     = CONF_W'(N_EVAL);
    localparam logic [CONF_W-1:0] HALF_C       = CONF_W'(N_EVAL / 2);
    localparam logic [CONF_W-1:0] CNT_ONE      = CONF_W'(1);
    localparam logic [TMR_W-1:0]  TMR_ONE      = TMR_W'(1);
    localparam logic [TMR_W-1:0]  SETTLE_LAST  = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  RECOVER_LAST = TMR_W'(RECOVER_CYCLES - 1);

    if (!params_ok(N_STAGES, N_EVAL, SETTLE_CYCLES, RECOVER_CYCLES)) begin : g_param_error
        $error("arbiter_puf_engine: illegal parameter combination");
    end

    state_t              state;
    state_t              state_next;
    logic [TMR_W-1:0]    timer;
    logic [N_STAGES-1:0] chal_q;
    logic [CONF_W-1:0]   ones_cnt;
    logic [CONF_W-1:0]   eval_cnt;
    logic                launch;
    (* dont_touch = "true", keep = "true" *) logic arb_raw;
    (* dont_touch = "true", keep = "true" *) logic sync1;
    (* dont_touch = "true", keep = "true" *) logic sync2;

    puf_delay_line #(.N_STAGES(N_STAGES)) u_delay_line (
        .launch  (launch),
        .chal    (chal_q),
        .arb_raw (arb_raw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (chal_valid) state_next = LAUNCH;
            LAUNCH:  state_next = SETTLE;
            SETTLE:  if (timer == SETTLE_LAST) state_next = SAMPLE;
            SAMPLE:  state_next = RECOVER;
            RECOVER: if (timer == RECOVER_LAST)
                         state_next = (eval_cnt < N_EVAL_C) ? LAUNCH : DONE;
            DONE:    if (resp_valid && resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Launch is a pure state decode so an async reset drops it without waiting for a clock.
    always_comb begin
        chal_ready = rst_n && (state == IDLE);
        busy       = (state != IDLE);
        launch     = (state == LAUNCH) || (state == SETTLE) || (state == SAMPLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    timer <= '0;
        else if (state_next != state)                  timer <= '0;
        else if ((state == SETTLE) || (state == RECOVER)) timer <= timer + TMR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= arb_raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chal_q   <= '0;
            ones_cnt <= '0;
            eval_cnt <= '0;
        end else if ((state == IDLE) && chal_valid) begin
            chal_q   <= chal;
            ones_cnt <= '0;
            eval_cnt <= '0;
        end else if (state == SAMPLE) begin
            ones_cnt <= ones_cnt + CONF_W'(sync2);
            eval_cnt <= eval_cnt + CNT_ONE;
        end
    end

    // The first DONE cycle latches the vote; the handshake is only possible from the second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp       <= 1'b0;
            resp_conf  <= '0;
        end else if (state == DONE) begin
            if (!resp_valid) begin
                resp_valid <= 1'b1;
                resp       <= (ones_cnt > HALF_C);
                resp_conf  <= ones_cnt;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule
